// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// pc_gen : IF-stage fetch-address generator (reset/trap/redirect/stall/BTB/+4)
// Optional direct-mapped branch target buffer enabled by macro PC_BTB_EN.
// Revision : 1.0
// ============================================================================
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BTB_DEPTH    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            bu_valid,
  input  logic [XLEN-1:0] bu_pc,
  input  logic [XLEN-1:0] bu_target,
  input  logic            bu_taken,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pred_taken,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_addr
);

  logic [XLEN-1:0] next_pc;
  logic            reject;
  logic [XLEN-1:0] reject_addr;
  logic            hit;
  logic [XLEN-1:0] hit_target;

  assign pc_plus4   = pc + XLEN'(4);
  assign pred_taken = hit;

`ifdef PC_BTB_EN
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
  logic [XLEN-1:0]      btb_target [BTB_DEPTH];
  logic [IDX_W-1:0]     rd_idx;
  logic [IDX_W-1:0]     wr_idx;
  logic [TAG_W-1:0]     rd_tag;
  logic [TAG_W-1:0]     wr_tag;
  logic                 unused_bu_lsb;

  assign rd_idx        = pc[IDX_W+1:2];
  assign rd_tag        = pc[XLEN-1:IDX_W+2];
  assign wr_idx        = bu_pc[IDX_W+1:2];
  assign wr_tag        = bu_pc[XLEN-1:IDX_W+2];
  assign unused_bu_lsb = ^bu_pc[1:0];

  // Lookup reads the arrays before this edge's update lands.
  assign hit        = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign hit_target = btb_target[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (bu_valid) begin
      if (bu_taken) begin
        btb_valid[wr_idx] <= 1'b1;
      end else if (btb_tag[wr_idx] == wr_tag) begin
        btb_valid[wr_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && bu_valid && bu_taken) begin
      btb_tag[wr_idx]    <= wr_tag;
      btb_target[wr_idx] <= bu_target;
    end
  end
`else
  logic                         unused_bu;
  logic [$clog2(BTB_DEPTH)-1:0] unused_depth;

  assign unused_bu    = ^{bu_valid, bu_pc, bu_target, bu_taken};
  assign unused_depth = pc[$clog2(BTB_DEPTH)+1:2];
  assign hit          = 1'b0;
  assign hit_target   = '0;
`endif

  // A misaligned trap/redirect freezes pc; lower-priority sources are not used instead.
  always_comb begin
    next_pc     = pc_plus4;
    reject      = 1'b0;
    reject_addr = trap_vec;
    if (trap) begin
      if (trap_vec[1:0] != 2'b00) begin
        reject  = 1'b1;
        next_pc = pc;
      end else begin
        next_pc = trap_vec;
      end
    end else if (redirect) begin
      reject_addr = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        reject  = 1'b1;
        next_pc = pc;
      end else begin
        next_pc = redirect_pc;
      end
    end else if (stall) begin
      next_pc = pc;
    end else if (hit) begin
      next_pc = hit_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_VECTOR;
      misalign      <= 1'b0;
      misalign_addr <= '0;
    end else begin
      pc       <= next_pc;
      misalign <= reject;
      if (reject) begin
        misalign_addr <= reject_addr;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator, the successor to the fixed 32-bit PC register / PC+4 / target-adder trio. Holds the architectural fetch PC and selects the next PC from reset vector, trap vector, execute-stage redirect, stall hold, optional branch-target-buffer prediction, or sequential increment. Sits at the head of the IF stage; its PC feeds instruction memory and the IF/ID pipe register.

## Interface
Parameters:
- XLEN, 32, PC and address width in bits.
- RESET_VECTOR, 0, PC value loaded on reset (XLEN bits, must be 4-aligned).
- BTB_DEPTH, 16, BTB entries; power of two, at least 2. Used only with PC_BTB_EN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold current PC (IF stage stalled).
- redirect  in  1  execute-stage branch/jump resolved to redirect_pc.
- redirect_pc  in  XLEN  redirect target.
- trap  in  1  take trap to trap_vec.
- trap_vec  in  XLEN  trap handler address.
- bu_valid  in  1  BTB update strobe from execute.
- bu_pc  in  XLEN  PC of the resolved branch.
- bu_target  in  XLEN  resolved target.
- bu_taken  in  1  branch was taken.
- pc  out  XLEN  current fetch PC (registered).
- pc_plus4  out  XLEN  pc + 4, combinational.
- pred_taken  out  1  BTB hit for current pc (0 when BTB compiled out).
- misalign  out  1  registered one-cycle pulse: rejected misaligned redirect/trap.
- misalign_addr  out  XLEN  offending address, held until the next rejection.

## Operation
- Next-PC priority, evaluated each cycle: rst > trap > redirect > stall > BTB hit > pc+4.
- trap / redirect override stall; the stall request is dropped for that cycle.
- Alignment: a trap_vec or redirect_pc with bits [1:0] != 0 is rejected: pc holds, misalign=1 next cycle, misalign_addr captures the address. A lower-priority aligned source is NOT taken in its place.
- Arithmetic: pc+4 and all addresses are modulo 2^XLEN; pc = 2^XLEN-4 increments to 0 with no flag.
- BTB (PC_BTB_EN): direct-mapped, index = pc[log2(BTB_DEPTH)+1:2], tag = pc[XLEN-1:log2(BTB_DEPTH)+2], payload = target, plus valid bit.
  - Lookup combinational on current pc; hit = valid && tag match → pred_taken=1, next pc = stored target (if no higher-priority event).
  - Update on bu_valid at posedge: bu_taken=1 → write valid/tag/target at bu_pc's index (overwrite any prior entry); bu_taken=0 and tag matches → clear valid; bu_taken=0 and miss → no change.
  - bu_valid is accepted regardless of stall, redirect, or trap.
  - Same-cycle lookup and update on the same index: lookup uses pre-update contents.

## Timing
- Reset values: pc=RESET_VECTOR, misalign=0, misalign_addr=0, all BTB valid bits=0, hence pred_taken=0. Reset mid-operation discards pending updates in that cycle.
- pc changes only at the rising edge; one-cycle latency from any select input to new pc.
- pc_plus4 and pred_taken are combinational from pc and BTB state; they are valid in the same cycle as pc.
- A BTB write becomes visible to lookup one cycle after its bu_valid cycle.
- misalign is high for exactly one cycle per rejected event; back-to-back rejections produce back-to-back pulses.

## Configuration
- PC_BTB_EN defined: BTB storage, lookup, and update logic present.
- PC_BTB_EN undefined: no BTB storage; bu_* inputs are ignored; pred_taken is tied to 0; next-PC order is rst > trap > redirect > stall > pc+4. BTB_DEPTH is unused.

## Test plan
- Reset then free run, RESET_VECTOR=0x100: pc sequence 0x100, 0x104, 0x108; pc_plus4 tracks pc+4 in each cycle.
- stall=1 with redirect=1 and redirect_pc=0x2000 in the same cycle: next pc=0x2000. stall alone for 3 cycles: pc is held for 3 cycles.
- trap=1 with trap_vec=0x80, together with redirect to 0x400: next pc=0x80. redirect_pc=0x402: pc holds, misalign pulses 1 cycle, misalign_addr=0x402.
- Wrap-around with XLEN=32 and pc=0xFFFFFFFC: next pc=0x00000000.
- BTB, PC_BTB_EN, depth 16: update bu_pc=0x40 with bu_target=0x200 and bu_taken=1. When pc next reaches 0x40: pred_taken=1 and next pc=0x200. Then update 0x40 with bu_taken=0: the entry invalidates, and on the next visit pc goes 0x40 → 0x44.
- BTB alias: entry for 0x40 is present; pc=0x80 (same index, different tag) gives pred_taken=0. Reset mid-run clears the entry, so pc 0x40 → 0x44.
